// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-port SRAM access arbiter.
// Owners the arbiter, the round-robin sub-block and the testbench all agree on.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [0:0] owner_t;

    localparam owner_t      OWNER_P0    = 1'b0;
    localparam owner_t      OWNER_P1    = 1'b1;
    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned CNT_W       = 8;

    function automatic owner_t other_port(input owner_t o);
        return ~o;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way winner select: a lone requester wins, a tie goes to the port that
// was not served last (round-robin) or always to port 0 (fixed priority).
module rr_arb2
    import sram_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req_i,
    input  owner_t     last_owner_i,
    output logic       valid_o,
    output owner_t     winner_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = OWNER_P0;
        case (req_i)
            2'b01:   winner_o = OWNER_P0;
            2'b10:   winner_o = OWNER_P1;
            2'b11:   winner_o = RR_EN ? other_port(last_owner_i) : OWNER_P0;
            default: winner_o = OWNER_P0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one SRAM controller port, one access at a
// time, with a bounded wait for controller ready and a timeout error pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no access; arbitrate and latch winner's wr/addr/wdata
// ST_ISSUE | first enable cycle; mem_ready not yet meaningful
// ST_WAIT  | enables held; wait for mem_ready or timeout
// ST_DONE  | enables low; owner's done (and err on timeout) pulses
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned RR_EN   = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic              p0_err_q, p0_err_d;
    logic              p1_err_q, p1_err_d;
    logic [31:0]       p0_rdata_q, p0_rdata_d;
    logic [31:0]       p1_rdata_q, p1_rdata_d;

    logic              arb_valid;
    owner_t            arb_winner;
    logic              access_active;

    rr_arb2 #(
        .RR_EN (RR_EN != 0)
    ) u_rr_arb2 (
        .req_i        ({p1_req, p0_req}),
        .last_owner_i (last_owner_q),
        .valid_o      (arb_valid),
        .winner_o     (arb_winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_done_d    = 1'b0;
        p1_done_d    = 1'b0;
        p0_err_d     = 1'b0;
        p1_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_winner;
                    if (arb_winner == OWNER_P1) begin
                        wr_d    = p1_wr;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                    end else begin
                        wr_d    = p0_wr;
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                    end
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (mem_ready) begin
                    state_d      = ST_DONE;
                    last_owner_d = owner_q;
                    if (owner_q == OWNER_P1) begin
                        p1_done_d = 1'b1;
                        if (!wr_q) p1_rdata_d = mem_rdata;
                    end else begin
                        p0_done_d = 1'b1;
                        if (!wr_q) p0_rdata_d = mem_rdata;
                    end
                end else if (cnt_q == TO_CNT) begin
                    // Abort: report completion with error, read data left untouched.
                    state_d      = ST_DONE;
                    last_owner_d = owner_q;
                    if (owner_q == OWNER_P1) begin
                        p1_done_d = 1'b1;
                        p1_err_d  = 1'b1;
                    end else begin
                        p0_done_d = 1'b1;
                        p0_err_d  = 1'b1;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_P0;
            last_owner_q <= OWNER_P1;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_err_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            p0_done_q    <= p0_done_d;
            p1_done_q    <= p1_done_d;
            p0_err_q     <= p0_err_d;
            p1_err_q     <= p1_err_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // Enables decode straight from state so an async reset drops them at once.
    assign access_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign mem_wr_en     = access_active &&  wr_q;
    assign mem_rd_en     = access_active && !wr_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

    assign p0_done  = p0_done_q;
    assign p1_done  = p1_done_q;
    assign p0_err   = p0_err_q;
    assign p1_err   = p1_err_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a latency-programmable SRAM controller model.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_wr, p0_done, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_wr, p1_done, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_wr_en, mem_rd_en, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] mem [0:1023];
    int          model_lat;
    logic        model_never;
    int          acc_cycles;

    int          low_run = 0;
    logic        prev_en = 1'b0;
    logic        seen_access = 1'b0;

    sram_arbiter #(
        .TIMEOUT (16),
        .RR_EN   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_wr     (p0_wr),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_done   (p0_done),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_wr     (p1_wr),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_done   (p1_done),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Controller model: ready pulses on the model_lat-th enabled cycle.
    always @(negedge clk) begin
        if (mem_rd_en || mem_wr_en) begin
            acc_cycles++;
            if (acc_cycles == model_lat && !model_never) begin
                mem_ready = 1'b1;
                if (mem_wr_en) mem[mem_addr[11:2]] = mem_wdata;
                else           mem_rdata = mem[mem_addr[11:2]];
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            acc_cycles = 0;
            mem_ready  = 1'b0;
        end
    end

    // Continuous protocol properties.
    always @(negedge clk) begin
        logic en;
        en = mem_rd_en | mem_wr_en;
        check("en_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
        check("done_onehot", 32'(p0_done & p1_done), 32'd0);
        if (en && !prev_en && seen_access)
            check("en_gap", 32'(low_run >= 2), 32'd1);
        if (en) begin
            low_run     = 0;
            seen_access = 1'b1;
        end else begin
            low_run++;
        end
        prev_en = en;
    end

    task automatic xact(input int port, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int cyc,
                        output logic [31:0] rdata, output logic err);
        int   n;
        logic got;
        logic done_now, other_now;
        if (port == 1) begin
            p1_req = 1'b1; p1_wr = wr; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_wr = wr; p0_addr = addr; p0_wdata = wdata;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (mem_rd_en || mem_wr_en) begin
                check("latched_addr", mem_addr, addr);
                check("latched_wr", 32'(mem_wr_en), 32'(wr));
                if (wr) check("latched_wdata", mem_wdata, wdata);
            end
            done_now  = (port == 1) ? p1_done : p0_done;
            other_now = (port == 1) ? p0_done : p1_done;
            check("other_done_low", 32'(other_now), 32'd0);
            if (done_now) got = 1'b1;
            if (n == 1) begin
                // Scramble request fields after grant; the access must not notice.
                if (port == 1) begin
                    p1_wr = ~wr; p1_addr = ~addr; p1_wdata = ~wdata;
                end else begin
                    p0_wr = ~wr; p0_addr = ~addr; p0_wdata = ~wdata;
                end
            end
        end
        if (!got) check("done_seen", 32'd0, 32'd1);
        cyc   = n - 1;
        rdata = (port == 1) ? p1_rdata : p0_rdata;
        err   = (port == 1) ? p1_err : p0_err;
        check("done_en_low", 32'(mem_rd_en | mem_wr_en), 32'd0);
        if (port == 1) p1_req = 1'b0; else p0_req = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'((port == 1) ? p1_done : p0_done), 32'd0);
        check("err_one_cycle", 32'((port == 1) ? p1_err : p0_err), 32'd0);
        check("rdata_held", (port == 1) ? p1_rdata : p0_rdata, rdata);
    endtask

    task automatic wait_done(output int cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p0_done || p1_done) && n < 100);
        if (!(p0_done || p1_done)) check("wait_done_bound", 32'd0, 32'd1);
        cyc = n;
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic        er;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[10'h100] = 32'h1234_5678;
        mem[10'h104] = 32'h1111_0001;
        mem[10'h105] = 32'h2222_0002;
        mem[10'h106] = 32'h3333_0003;
        mem[10'h107] = 32'h4444_0004;
        model_lat   = 5;
        model_never = 1'b0;
        acc_cycles  = 0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        p0_req = 1'b0; p0_wr = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wdata = '0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);
        check("rst_done", 32'({p1_done, p0_done}), 32'd0);
        check("rst_err", 32'({p1_err, p0_err}), 32'd0);
        check("rst_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single read, 5-cycle controller latency.
        xact(0, 1'b0, 32'h0000_0400, 32'h0, cyc, rd, er);
        check("rd400_latency", 32'(cyc), 32'd5);
        check("rd400_rdata", rd, 32'h1234_5678);
        check("rd400_err", 32'(er), 32'd0);
        check("rd400_p1_rdata", p1_rdata, 32'd0);

        // Write from p1, read back via p0.
        xact(1, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, cyc, rd, er);
        check("wr408_err", 32'(er), 32'd0);
        check("wr408_p1_rdata_kept", rd, 32'd0);
        xact(0, 1'b0, 32'h0000_0408, 32'h0, cyc, rd, er);
        check("rb408_rdata", rd, 32'hDEAD_BEEF);

        // Round-robin from reset.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 32'h0000_0410;
        p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 32'h0000_0414;
        wait_done(cyc);
        check("rr1_p0_first", 32'(p0_done), 32'd1);
        check("rr1_p1_waits", 32'(p1_done), 32'd0);
        check("rr1_p0_rdata", p0_rdata, 32'h1111_0001);
        p0_req = 1'b0;
        wait_done(cyc);
        check("rr1_p1_second", 32'(p1_done), 32'd1);
        check("rr1_p1_rdata", p1_rdata, 32'h2222_0002);
        p1_req = 1'b0;
        @(negedge clk);
        xact(1, 1'b0, 32'h0000_0414, 32'h0, cyc, rd, er);
        check("rr2_p1_alone", rd, 32'h2222_0002);
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 32'h0000_0418;
        p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 32'h0000_041C;
        wait_done(cyc);
        check("rr2_p0_wins", 32'(p0_done), 32'd1);
        check("rr2_p0_rdata", p0_rdata, 32'h3333_0003);
        p0_req = 1'b0;
        wait_done(cyc);
        check("rr2_p1_next", 32'(p1_done), 32'd1);
        check("rr2_p1_rdata", p1_rdata, 32'h4444_0004);
        p1_req = 1'b0;
        @(negedge clk);

        // Controller never ready: timeout abort.
        model_never = 1'b1;
        xact(0, 1'b0, 32'h0000_0500, 32'h0, cyc, rd, er);
        check("to_latency", 32'(cyc), 32'd18);
        check("to_err", 32'(er), 32'd1);
        check("to_rdata_kept", rd, 32'h3333_0003);
        model_never = 1'b0;

        // Reset while waiting on the controller.
        model_never = 1'b1;
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 32'h0000_0400;
        repeat (6) @(negedge clk);
        check("rstw_in_access", 32'(mem_rd_en), 32'd1);
        rst = 1'b0;
        #1;
        check("rstw_en_drop", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        p0_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rstw_no_done", 32'({p1_done, p0_done}), 32'd0);
        end
        check("rstw_p0_rdata", p0_rdata, 32'd0);
        model_never = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        xact(0, 1'b0, 32'h0000_0400, 32'h0, cyc, rd, er);
        check("post_rst_latency", 32'(cyc), 32'd5);
        check("post_rst_rdata", rd, 32'h1234_5678);
        check("post_rst_err", 32'(er), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, cycles WAIT may last before abort (range 4..255).
REQ-002 Parameter: RR_EN, default 1; 1 = round-robin, 0 = port 0 fixed priority.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 pN_req  input  1  (N=0,1) requester N access request, held until pN_done.
REQ-006 pN_wr  input  1  1 = write, 0 = read; sampled at grant.
REQ-007 pN_addr  input  32  byte address; sampled at grant.
REQ-008 pN_wdata  input  32  write data; sampled at grant.
REQ-009 pN_done  output  1  one-cycle completion pulse to requester N.
REQ-010 pN_rdata  output  32  read data, valid while pN_done=1, held until next completion to N.
REQ-011 pN_err  output  1  one-cycle timeout pulse, coincident with pN_done.
REQ-012 mem_wr_en  output  1  write enable to SRAM controller.
REQ-013 mem_rd_en  output  1  read enable to SRAM controller.
REQ-014 mem_addr  output  32  address to SRAM controller (ALU_Res input).
REQ-015 mem_wdata  output  32  write data to SRAM controller.
REQ-016 mem_rdata  input  32  read data from SRAM controller.
REQ-017 mem_ready  input  1  controller ready; low while an access is in flight.

Function
REQ-018 States: IDLE, ISSUE, WAIT, DONE; encoding from shared package.
REQ-019 IDLE: no req -> stay; any req -> latch winner's wr/addr/wdata and owner id, go ISSUE.
REQ-020 Arbitration: single req wins; both req with RR_EN=1 -> port other than last_owner wins; RR_EN=0 -> port 0 wins.
REQ-021 last_owner updates on entry to DONE.
REQ-022 ISSUE: drive mem_rd_en/mem_wr_en per latched wr, mem_addr, mem_wdata; mem_ready ignored; go WAIT after one cycle.
REQ-023 WAIT: enables and address held; mem_ready=1 -> capture mem_rdata (reads only) into owner's pN_rdata, go DONE.
REQ-024 WAIT: counter increments each cycle; at TIMEOUT with mem_ready=0 -> go DONE with error flag set, pN_rdata unchanged.
REQ-025 DONE: enables low, pN_done=1 for owner only, pN_err=error flag; go IDLE; error flag cleared.
REQ-026 mem_wr_en and mem_rd_en never both 1; both 0 outside ISSUE/WAIT.
REQ-027 Minimum turnaround: one IDLE cycle between DONE and next ISSUE, so controller sees enables low at least 2 cycles.
REQ-028 req drop mid-transaction: access completes, done still pulses; no abort.
REQ-029 Latched fields immune to pN_* changes after grant.
REQ-030 Counter 8 bits, saturates, reset on ISSUE entry.
REQ-031 All outputs registered except mem_* enables/address/data, which decode from state and latches.

Reset
REQ-032 rst=0 asynchronously forces IDLE, last_owner=1 (port 0 first), counter=0, error flag=0, pN_rdata=0, all done/err/enables=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset mid-access drops enables immediately; no done pulse issued.

Structure
REQ-034 State enum, owner id type and default TIMEOUT in shared package sram_pkg.
REQ-035 Sub-module rr_arb2 (2-way round-robin winner select) natural; rest flat.

Verification
REQ-036 p0 read addr 0x400, controller model ready after 5 cycles -> p0_done 1 cycle, p0_rdata=model word, p1 idle.
REQ-037 p0 and p1 req same cycle, RR_EN=1, after reset -> p0 served first, p1 next; second round p1 req alone then both -> p0 served.
REQ-038 p1 write 0xDEADBEEF to 0x408 -> mem_wr_en high ISSUE..WAIT, mem_wdata stable, readback via p0 returns 0xDEADBEEF.
REQ-039 Model never raises ready, TIMEOUT=16 -> done+err at cycle 18 after grant, enables low, rdata unchanged.
REQ-040 rst asserted in WAIT -> enables 0 same cycle, no done; post-reset read completes normally.
REQ-041 Assertion throughout: never both enables; done one-hot per transaction; enables low at least 2 cycles between accesses.
